// File: rtl/cmp_pkg.sv
// Shared definitions for the window statistics stage and its magnitude comparator.
package cmp_pkg;

    localparam int unsigned DATA_W_DEFAULT = 4;

    typedef enum logic [1:0] {
        ST_FIRST = 2'd0,
        ST_ACCUM = 2'd1,
        ST_HOLD  = 2'd2
    } state_e;

    // Ceiling log2; returns 0 for v <= 1.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(v)) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/window_stats_tracker_cmp.sv
// Unsigned magnitude comparator: exactly one of alb/aeb/agb is high.
module mag_cmp
    import cmp_pkg::*;
#(
    parameter int unsigned W = DATA_W_DEFAULT
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         alb,
    output logic         aeb,
    output logic         agb
);

    assign alb = (a <  b);
    assign aeb = (a == b);
    assign agb = (a >  b);

endmodule

// File: rtl/window_stats_tracker.sv
// Per-window max/min and rising/falling/flat step counts over a stream of
// unsigned samples, delivered through a one-deep valid/ready output register.
module window_stats_tracker
    import cmp_pkg::*;
#(
    parameter  int unsigned DATA_W = DATA_W_DEFAULT,
    parameter  int unsigned WINDOW = 8,
    localparam int unsigned CNT_W  = clog2(WINDOW)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_max,
    output logic [DATA_W-1:0] out_min,
    output logic [CNT_W-1:0]  out_up,
    output logic [CNT_W-1:0]  out_down,
    output logic [CNT_W-1:0]  out_flat
);

    state_e              state_q, state_d;
    logic [DATA_W-1:0]   max_q, max_d;
    logic [DATA_W-1:0]   min_q, min_d;
    logic [DATA_W-1:0]   prev_q, prev_d;
    logic [CNT_W-1:0]    up_q, up_d;
    logic [CNT_W-1:0]    down_q, down_d;
    logic [CNT_W-1:0]    flat_q, flat_d;
    logic [CNT_W-1:0]    idx_q, idx_d;

    logic                out_valid_q, out_valid_d;
    logic [DATA_W-1:0]   out_max_q, out_max_d;
    logic [DATA_W-1:0]   out_min_q, out_min_d;
    logic [CNT_W-1:0]    out_up_q, out_up_d;
    logic [CNT_W-1:0]    out_down_q, out_down_d;
    logic [CNT_W-1:0]    out_flat_q, out_flat_d;

    logic alb_p, aeb_p, agb_p;
    logic alb_m, aeb_m, agb_m;
    logic alb_n, aeb_n, agb_n;

    mag_cmp #(.W(DATA_W)) u_cmp_prev (
        .a   (in_data),
        .b   (prev_q),
        .alb (alb_p),
        .aeb (aeb_p),
        .agb (agb_p)
    );

    mag_cmp #(.W(DATA_W)) u_cmp_max (
        .a   (in_data),
        .b   (max_q),
        .alb (alb_m),
        .aeb (aeb_m),
        .agb (agb_m)
    );

    mag_cmp #(.W(DATA_W)) u_cmp_min (
        .a   (in_data),
        .b   (min_q),
        .alb (alb_n),
        .aeb (aeb_n),
        .agb (agb_n)
    );

    // Only the "new extreme" outputs of the max/min comparators matter.
    logic unused_cmp;
    assign unused_cmp = &{1'b0, alb_m, aeb_m, aeb_n, agb_n};

    logic              in_fire;
    logic              last;
    logic [DATA_W-1:0] max_n, min_n;
    logic [CNT_W-1:0]  up_n, down_n, flat_n;

    assign in_ready = !rst && (state_q != ST_HOLD);
    assign in_fire  = in_valid && in_ready;
    assign last     = (idx_q == CNT_W'(WINDOW - 1));

    assign max_n  = agb_m ? in_data : max_q;
    assign min_n  = alb_n ? in_data : min_q;
    assign up_n   = up_q   + CNT_W'(agb_p);
    assign down_n = down_q + CNT_W'(alb_p);
    assign flat_n = flat_q + CNT_W'(aeb_p);

    always_comb begin
        state_d     = state_q;
        max_d       = max_q;
        min_d       = min_q;
        prev_d      = prev_q;
        up_d        = up_q;
        down_d      = down_q;
        flat_d      = flat_q;
        idx_d       = idx_q;
        out_valid_d = out_valid_q;
        out_max_d   = out_max_q;
        out_min_d   = out_min_q;
        out_up_d    = out_up_q;
        out_down_d  = out_down_q;
        out_flat_d  = out_flat_q;

        unique case (state_q)
            ST_FIRST: begin
                if (in_fire) begin
                    max_d   = in_data;
                    min_d   = in_data;
                    prev_d  = in_data;
                    up_d    = '0;
                    down_d  = '0;
                    flat_d  = '0;
                    idx_d   = CNT_W'(1);
                    state_d = ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                if (in_fire) begin
                    max_d  = max_n;
                    min_d  = min_n;
                    prev_d = in_data;
                    up_d   = up_n;
                    down_d = down_n;
                    flat_d = flat_n;
                    idx_d  = idx_q + CNT_W'(1);
                    if (last) begin
                        out_max_d   = max_n;
                        out_min_d   = min_n;
                        out_up_d    = up_n;
                        out_down_d  = down_n;
                        out_flat_d  = flat_n;
                        out_valid_d = 1'b1;
                        state_d     = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (out_valid_q && out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_FIRST;
                end
            end
            default: state_d = ST_FIRST;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_FIRST;
            max_q       <= '0;
            min_q       <= '0;
            prev_q      <= '0;
            up_q        <= '0;
            down_q      <= '0;
            flat_q      <= '0;
            idx_q       <= '0;
            out_valid_q <= 1'b0;
            out_max_q   <= '0;
            out_min_q   <= '0;
            out_up_q    <= '0;
            out_down_q  <= '0;
            out_flat_q  <= '0;
        end else begin
            state_q     <= state_d;
            max_q       <= max_d;
            min_q       <= min_d;
            prev_q      <= prev_d;
            up_q        <= up_d;
            down_q      <= down_d;
            flat_q      <= flat_d;
            idx_q       <= idx_d;
            out_valid_q <= out_valid_d;
            out_max_q   <= out_max_d;
            out_min_q   <= out_min_d;
            out_up_q    <= out_up_d;
            out_down_q  <= out_down_d;
            out_flat_q  <= out_flat_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_max   = out_max_q;
    assign out_min   = out_min_q;
    assign out_up    = out_up_q;
    assign out_down  = out_down_q;
    assign out_flat  = out_flat_q;

endmodule
